// File: rtl/fifo_level_if.sv
// fifo_level_if: handshake/data/status bundle between a producer/consumer
// (master) and the fifo_level buffer (slave).
//   rd, wr, w_data, err_clr        : requests from the master
//   r_data                         : show-ahead head word
//   empty, full, almost_empty,
//   almost_full, count             : registered occupancy status
//   overflow, underflow            : sticky error flags
interface fifo_level_if #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
);
    logic         rd;
    logic         wr;
    logic [B-1:0] w_data;
    logic         err_clr;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;

    modport master (
        output rd, wr, w_data, err_clr,
        input  r_data, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  rd, wr, w_data, err_clr,
        output r_data, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with register-file storage, show-ahead read
// port, occupancy count and programmable almost-full/almost-empty levels.
// A write while full is accepted when a read happens in the same cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : fifo_level_if.slave (rd/wr/w_data/err_clr in; r_data and
//            status out)
// Build option:
//   FIFO_LEVEL_ERR_EN defined   -> sticky overflow/underflow with err_clr
//   FIFO_LEVEL_ERR_EN undefined -> overflow/underflow tied 0, err_clr ignored
module fifo_level #(
    parameter int unsigned B        = 8,
    parameter int unsigned W        = 4,
    parameter int unsigned AF_LEVEL = 2**W - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic         clk,
    input logic         reset,
    fifo_level_if.slave bus
);
    localparam int unsigned DEPTH = 2**W;
    localparam int unsigned CW    = W + 1;

    logic [B-1:0]  mem [DEPTH];
    logic [W-1:0]  w_ptr, r_ptr, w_ptr_next, r_ptr_next;
    logic [CW-1:0] count_q, count_next;
    logic          empty_q, full_q, ae_q, af_q;
    logic          empty_next, full_next, ae_next, af_next;
    logic          do_rd, do_wr;

    // Effective handshakes: a read needs data, a write needs room or a
    // concurrent read freeing a slot.
    assign do_rd = bus.rd & ~empty_q;
    assign do_wr = bus.wr & (~full_q | do_rd);

    // Next pointers, count and status derived from next count.
    always_comb begin
        w_ptr_next = w_ptr;
        r_ptr_next = r_ptr;
        count_next = count_q;
        if (do_wr) w_ptr_next = w_ptr + W'(1);
        if (do_rd) r_ptr_next = r_ptr + W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
        empty_next = (count_next == '0);
        full_next  = (count_next == CW'(DEPTH));
        // 32-bit compare so out-of-range levels behave naturally.
        ae_next    = (32'(count_next) <= AE_LEVEL);
        af_next    = (32'(count_next) >= AF_LEVEL);
    end

    // Pointer, count and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
        end else begin
            w_ptr   <= w_ptr_next;
            r_ptr   <= r_ptr_next;
            count_q <= count_next;
            empty_q <= empty_next;
            full_q  <= full_next;
            ae_q    <= ae_next;
            af_q    <= af_next;
        end
    end

    // Storage is not reset; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem[w_ptr] <= bus.w_data;
    end

    // Show-ahead: head word is presented combinationally.
    assign bus.r_data       = mem[r_ptr];
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;

`ifdef FIFO_LEVEL_ERR_EN
    logic ovf_q, unf_q;

    // Sticky error flags; a clear wins over an error in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr & ~do_wr) ovf_q <= 1'b1;
            if (bus.rd & empty_q) unf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed self-checking bench for fifo_level with
// B=8, W=2, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_level;
`ifdef FIFO_LEVEL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fifo_level_if #(.B(8), .W(2)) bus ();

    fifo_level #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status snapshot: count, empty, full, almost_empty, almost_full.
    task automatic chk_st(input string tag, input int cnt, input bit e, input bit f,
                          input bit ae, input bit af);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(e));
        chk({tag, ".full"},  32'(bus.full),  32'(f));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(ae));
        chk({tag, ".af"},    32'(bus.almost_full),  32'(af));
    endtask

    task automatic chk_err(input string tag, input bit ov, input bit uf);
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(ov & ERR));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(uf & ERR));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr = 1'b1; bus.w_data = d;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic fill4;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    endtask

    // Pop four words checking the head before each edge.
    task automatic drain4(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] exp [4];
        exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
        bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.r_data%0d", tag, i), 32'(bus.r_data), 32'(exp[i]));
            tick();
        end
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.w_data = '0; bus.err_clr = 1'b0;
        reset = 1'b1;
        #12;
        chk_st("reset", 0, 1, 0, 1, 0);
        chk_err("reset", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill
        push(8'h11); chk_st("fill1", 1, 0, 0, 1, 0); chk("fill1.r_data", 32'(bus.r_data), 32'h11);
        push(8'h22); chk_st("fill2", 2, 0, 0, 0, 0);
        push(8'h33); chk_st("fill3", 3, 0, 0, 0, 1);
        push(8'h44); chk_st("fill4", 4, 0, 1, 0, 1); chk("fill4.r_data", 32'(bus.r_data), 32'h11);

        // Drain
        drain4("drain", 8'h11, 8'h22, 8'h33, 8'h44);
        chk_st("drained", 0, 1, 0, 1, 0);
        chk_err("drained", 0, 0);

        // Full pass-through with pointer wrap
        fill4();
        bus.rd = 1'b1; bus.wr = 1'b1; bus.w_data = 8'h55;
        tick();
        bus.rd = 1'b0; bus.wr = 1'b0;
        chk_st("pass", 4, 0, 1, 0, 1);
        drain4("pass_drain", 8'h22, 8'h33, 8'h44, 8'h55);
        chk_err("pass", 0, 0);

        // Overflow: write while full, no read
        fill4();
        push(8'h66);
        chk_st("ovf", 4, 0, 1, 0, 1);
        chk_err("ovf", 1, 0);
        drain4("ovf_drain", 8'h11, 8'h22, 8'h33, 8'h44);

        // Underflow: read while empty
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk_st("unf", 0, 1, 0, 1, 0);
        chk_err("unf", 1, 1);

        // Clear; then clear beats a new underflow in the same cycle
        bus.err_clr = 1'b1;
        tick();
        chk_err("clr", 0, 0);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0; bus.err_clr = 1'b0;
        chk_err("clr_prio", 0, 0);

        // Empty + rd + wr: write taken, read ignored
        bus.rd = 1'b1; bus.wr = 1'b1; bus.w_data = 8'hA5;
        tick();
        bus.rd = 1'b0; bus.wr = 1'b0;
        chk_st("empty_rw", 1, 0, 0, 1, 0);
        chk("empty_rw.r_data", 32'(bus.r_data), 32'hA5);
        chk_err("empty_rw", 0, 1);

        // Async reset mid-fill (count 2), flags set beforehand
        push(8'h01);
        chk_st("pre_rst", 2, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_st("async_rst", 0, 1, 0, 1, 0);
        chk_err("async_rst", 0, 0);
        #1 reset = 1'b0;
        push(8'h77);
        chk_st("post_rst", 1, 0, 0, 1, 0);
        chk("post_rst.r_data", 32'(bus.r_data), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised synchronous FIFO: register-file storage, show-ahead read port, and an occupancy count.
- Adds programmable almost-full/almost-empty thresholds.
- Accepts a write while full, provided a read happens in the same cycle.
- Drop-in buffer between producer/consumer blocks (UART, BRAM streaming) in the lab designs.

Parameters:
- B, 8, data word width in bits
- W, 4, address bits; depth = 2**W words
- AF_LEVEL, 2**W-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rd  input  1  read request (pop head word)
- wr  input  1  write request (push w_data)
- w_data  input  B  write data
- r_data  output  B  head word (show-ahead)
- empty  output  1  FIFO holds 0 words
- full  output  1  FIFO holds 2**W words
- almost_empty  output  1  count <= AE_LEVEL
- almost_full  output  1  count >= AF_LEVEL
- count  output  W+1  current occupancy, 0..2**W
- overflow  output  1  sticky: write refused
- underflow  output  1  sticky: read on empty
- err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - w_ptr = r_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - overflow = underflow = 0.
  - r_data is undefined; memory is not cleared.
- Reset mid-operation discards contents immediately; the first write after release lands at address 0.
- Read data:
  - r_data = mem[r_ptr] combinationally; the head word is valid whenever empty = 0.
  - A rd pops it at the next rising edge.
  - Zero-cycle read latency; a write becomes visible on r_data the cycle after the write edge.
- Effective handshake terms:
  - do_rd = rd & ~empty
  - do_wr = wr & (~full | do_rd)
- Per edge:
  - do_wr: mem[w_ptr] <= w_data; w_ptr += 1.
  - do_rd: r_ptr += 1.
  - count: +1 if do_wr only; -1 if do_rd only; unchanged if both or neither.
- Pointers are W bits and wrap modulo 2**W with no special handling.
- Status outputs:
  - empty, full, almost_empty and almost_full are registered, updated from next-count.
  - No combinational path from rd/wr to any status output.
- Boundary cases:
  - Empty + rd + wr: write accepted, read ignored; underflow set; count -> 1.
  - Full + rd + wr: both performed; count stays 2**W; full stays 1; new word lands in the slot just vacated.
  - Full + wr only: write dropped, pointers unchanged, overflow set.
  - Empty + rd only: no change, underflow set.
- Error flags:
  - overflow/underflow stay set until err_clr or reset.
  - err_clr has priority over a new error in the same cycle.
- Thresholds:
  - Compared against W+1-bit count.
  - AF_LEVEL > 2**W means almost_full is never asserted.

Optional Feature:
- Macro: FIFO_LEVEL_ERR_EN.
- Defined: overflow/underflow sticky logic and err_clr behave as above.
- Undefined:
  - Ports remain; overflow and underflow are tied to 0; err_clr is ignored.
  - No error registers are synthesised.
  - All other behaviour is identical.

Test Plan (B=8, W=2, AF_LEVEL=3, AE_LEVEL=1, macro defined):
- Fill: reset, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4.
  - almost_empty drops at count 2.
  - almost_full rises at count 3.
  - full = 1 at count 4; r_data = 0x11 throughout.
- Drain: from full, rd for 4 cycles -> r_data 0x11, 0x22, 0x33, 0x44.
  - empty = 1 after the 4th edge; count = 0; underflow stays 0.
- Full pass-through: full with 0x11..0x44, rd+wr w_data=0x55 -> count 4, full 1.
  - Subsequent drain yields 0x22, 0x33, 0x44, 0x55 (pointer wrap).
  - overflow stays 0.
- Errors:
  - Full, wr=1 w_data=0x66 -> overflow = 1, contents unchanged.
  - Then empty and rd=1 -> underflow = 1.
  - err_clr pulse -> both 0 next cycle.
- Empty simultaneous: empty, rd+wr w_data=0xA5 -> count 1, r_data = 0xA5, underflow = 1.
- Async reset: assert reset mid-fill (count 2) between clock edges -> count = 0, empty = 1, flags 0 immediately.
  - After release, write 0x77 -> r_data = 0x77.
